// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD write controller: autonomous power-on init, then valid/ready byte writes.
// Define LCD_4BIT_MODE_EN to drive only lcd_db[7:4] and split each byte into two nibble pulses.
module lcd_hd44780_ctrl #(
  parameter int CLK_KHZ    = 50000,
  parameter int E_HIGH_CYC = 25,
  parameter int POWERUP_US = 20000,
  parameter int CMD_US     = 50,
  parameter int SLOW_US    = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db
);
  localparam int          CYC_US   = CLK_KHZ / 1000;
  localparam logic [31:0] PWR_CYC  = 32'(POWERUP_US * CYC_US);
  localparam logic [31:0] CMD_CYC  = 32'(CMD_US * CYC_US);
  localparam logic [31:0] SLOW_CYC = 32'(SLOW_US * CYC_US);
  localparam logic [31:0] C4100    = 32'(4100 * CYC_US);
  localparam logic [31:0] C100     = 32'(100 * CYC_US);
  localparam logic [31:0] E_CYC    = 32'(E_HIGH_CYC);
`ifdef LCD_4BIT_MODE_EN
  localparam logic [3:0]  N_INIT   = 4'd8;
`else
  localparam logic [3:0]  N_INIT   = 4'd7;
`endif

  typedef enum logic [1:0] {W_4100, W_100, W_CMD, W_SLOW} wclass_t;
  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, E_HIGH, E_LOW, WAIT, IDLE
`ifdef LCD_4BIT_MODE_EN
    , NIB_GAP
`endif
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [3:0]  idx;
  wclass_t     wcls;
  logic [7:0]  rom_byte;
  wclass_t     rom_cls;
`ifdef LCD_4BIT_MODE_EN
  logic        rom_single;
  logic [3:0]  lo_nib;
  logic        two_nib;
`endif

  function automatic logic [31:0] class_cyc(input wclass_t c);
    case (c)
      W_4100:  return C4100;
      W_100:   return C100;
      W_SLOW:  return SLOW_CYC;
      default: return CMD_CYC;
    endcase
  endfunction

  always_comb begin
    rom_byte = 8'h00;
    rom_cls  = W_CMD;
`ifdef LCD_4BIT_MODE_EN
    rom_single = 1'b0;
    case (idx)
      4'd0: begin rom_byte = 8'h30; rom_cls = W_4100; rom_single = 1'b1; end
      4'd1: begin rom_byte = 8'h30; rom_cls = W_100;  rom_single = 1'b1; end
      4'd2: begin rom_byte = 8'h30; rom_single = 1'b1; end
      4'd3: begin rom_byte = 8'h20; rom_single = 1'b1; end
      4'd4: rom_byte = 8'h28;
      4'd5: rom_byte = 8'h0C;
      4'd6: rom_byte = 8'h06;
      4'd7: begin rom_byte = 8'h01; rom_cls = W_SLOW; end
      default: ;
    endcase
`else
    case (idx)
      4'd0: begin rom_byte = 8'h30; rom_cls = W_4100; end
      4'd1: begin rom_byte = 8'h30; rom_cls = W_100; end
      4'd2: rom_byte = 8'h30;
      4'd3: rom_byte = 8'h38;
      4'd4: rom_byte = 8'h0C;
      4'd5: rom_byte = 8'h06;
      4'd6: begin rom_byte = 8'h01; rom_cls = W_SLOW; end
      default: ;
    endcase
`endif
  end

  assign lcd_rw = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      idx       <= '0;
      wcls      <= W_CMD;
      req_ready <= 1'b0;
      init_done <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_db    <= 8'h00;
`ifdef LCD_4BIT_MODE_EN
      lo_nib    <= 4'h0;
      two_nib   <= 1'b0;
`endif
    end else begin
      case (state)
        PWR_WAIT:
          if (cnt == PWR_CYC - 32'd1) begin
            cnt   <= '0;
            state <= INIT_LOAD;
          end else cnt <= cnt + 32'd1;
        INIT_LOAD: begin
          idx    <= idx + 4'd1;
          wcls   <= rom_cls;
          lcd_rs <= 1'b0;
`ifdef LCD_4BIT_MODE_EN
          lcd_db  <= {rom_byte[7:4], 4'h0};
          lo_nib  <= rom_byte[3:0];
          two_nib <= !rom_single;
`else
          lcd_db <= rom_byte;
`endif
          state  <= SETUP;
        end
        IDLE:
          if (req_valid) begin
            req_ready <= 1'b0;
            lcd_rs    <= req_rs;
            // clear and return-home need the long execution time
            wcls      <= (!req_rs && req_data[7:2] == 6'd0 && req_data[1:0] != 2'd0)
                         ? W_SLOW : W_CMD;
`ifdef LCD_4BIT_MODE_EN
            lcd_db  <= {req_data[7:4], 4'h0};
            lo_nib  <= req_data[3:0];
            two_nib <= 1'b1;
`else
            lcd_db <= req_data;
`endif
            state <= SETUP;
          end
        SETUP: begin
          lcd_e <= 1'b1;
          cnt   <= '0;
          state <= E_HIGH;
        end
        E_HIGH:
          if (cnt == E_CYC - 32'd1) begin
            lcd_e <= 1'b0;
            cnt   <= '0;
            state <= E_LOW;
          end else cnt <= cnt + 32'd1;
        E_LOW: begin
`ifdef LCD_4BIT_MODE_EN
          if (two_nib) begin
            two_nib <= 1'b0;
            lcd_db  <= {lo_nib, 4'h0};
            state   <= NIB_GAP;
          end else state <= WAIT;
`else
          state <= WAIT;
`endif
        end
`ifdef LCD_4BIT_MODE_EN
        NIB_GAP:
          if (cnt == E_CYC - 32'd1) begin
            lcd_e <= 1'b1;
            cnt   <= '0;
            state <= E_HIGH;
          end else cnt <= cnt + 32'd1;
`endif
        WAIT:
          if (cnt == class_cyc(wcls) - 32'd1) begin
            cnt <= '0;
            if (!init_done && idx != N_INIT) state <= INIT_LOAD;
            else begin
              init_done <= 1'b1;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end else cnt <= cnt + 32'd1;
        default: state <= PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: init sequence, timed writes, reset abort.
// Also covers the nibble build when LCD_4BIT_MODE_EN is defined.
module tb_lcd_hd44780_ctrl;
  localparam int CLK_KHZ = 1000, E_HIGH_CYC = 2, POWERUP_US = 200, CMD_US = 5, SLOW_US = 20;
  localparam int CPU    = CLK_KHZ / 1000;
  localparam int D_CMD  = CMD_US * CPU;
  localparam int D_SLOW = SLOW_US * CPU;
  localparam int PWR    = POWERUP_US * CPU;
`ifdef LCD_4BIT_MODE_EN
  localparam int PULSES = 2;
  localparam int N_STEP = 8;
  logic [7:0] init_bytes [N_STEP] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h06, 8'h01};
  bit         init_nib   [N_STEP] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
  localparam int PULSES = 1;
  localparam int N_STEP = 7;
  logic [7:0] init_bytes [N_STEP] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h06, 8'h01};
`endif

  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic req_ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;
  int checks = 0, errors = 0, cyc = 0;

  lcd_hd44780_ctrl #(
    .CLK_KHZ(CLK_KHZ), .E_HIGH_CYC(E_HIGH_CYC), .POWERUP_US(POWERUP_US),
    .CMD_US(CMD_US), .SLOW_US(SLOW_US)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs),
    .req_data(req_data), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rs; logic [7:0] db; int cyc; } fall_t;
  typedef struct { logic e; int n; logic [7:0] db; } seg_t;
  typedef struct { logic rs; logic [7:0] data; int exp_d; } vec_t;

  // every E falling edge (the LCD's latch point) with the bus it latched
  fall_t fall_q[$];
  logic  prev_e = 1'b0;
  always @(negedge clk) begin
    if (rst && prev_e && !lcd_e) fall_q.push_back('{lcd_rs, lcd_db, cyc});
    prev_e <= rst & lcd_e;
  end

  logic [7:0] init_exp[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!req_ready && n < 30000) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic run_init(input bit hold);
    int base, t0, first_rise, n, early;
    base = fall_q.size();
    first_rise = -1; early = 0; n = 0;
    if (hold) begin req_rs = 1'b1; req_data = 8'h55; req_valid = 1'b1; end
    @(negedge clk);
    rst = 1'b1;
    t0 = cyc;
    while (!init_done && n < 30000) begin
      @(negedge clk); n++;
      if (lcd_e && first_rise < 0) first_rise = cyc;
      if (req_ready !== init_done) early++;
    end
    chk("init_done_timeout", 32'(init_done), 32'd1);
    chk("ready_with_init_done", 32'(req_ready), 32'd1);
    chk("ready_before_init", 32'(early), 32'd0);
    chk("powerup_quiet", 32'(first_rise - t0 > PWR), 32'd1);
    chk("init_fall_count", 32'(fall_q.size() - base), 32'(init_exp.size()));
    for (int i = 0; i < init_exp.size() && base + i < fall_q.size(); i++)
      chk($sformatf("init_step%0d {rs,db}", i), 32'({fall_q[base+i].rs, fall_q[base+i].db}),
          32'({1'b0, init_exp[i]}));
    if (fall_q.size() > base)
      chk("init_done_latency", 32'(cyc - fall_q[fall_q.size()-1].cyc), 32'(1 + D_SLOW));
  endtask

  task automatic do_write(input logic rs, input logic [7:0] data, input int d, input bit stray);
    seg_t segs[$];
    int t, tot, wait_start;
    logic [7:0] p1;
`ifdef LCD_4BIT_MODE_EN
    logic [7:0] p0;
    p0 = {data[7:4], 4'h0};
    p1 = {data[3:0], 4'h0};
    segs.push_back('{1'b0, 1, p0});
    segs.push_back('{1'b1, E_HIGH_CYC, p0});
    segs.push_back('{1'b0, 1, p0});
    segs.push_back('{1'b0, E_HIGH_CYC, p1});
    segs.push_back('{1'b1, E_HIGH_CYC, p1});
    segs.push_back('{1'b0, 1, p1});
`else
    p1 = data;
    segs.push_back('{1'b0, 1, p1});
    segs.push_back('{1'b1, E_HIGH_CYC, p1});
    segs.push_back('{1'b0, 1, p1});
`endif
    segs.push_back('{1'b0, d, p1});
    tot = 0;
    for (int s = 0; s < segs.size() - 1; s++) tot += segs[s].n;
    wait_start = tot + 1;
    wait_ready;
    req_rs = rs; req_data = data; req_valid = 1'b1;
    t = 0;
    foreach (segs[s]) begin
      for (int i = 0; i < segs[s].n; i++) begin
        @(negedge clk); t++;
        if (t == 1) req_valid = 1'b0;
        if (stray && t == wait_start) begin req_valid = 1'b1; req_data = ~data; req_rs = ~rs; end
        if (stray && t == wait_start + 1) req_valid = 1'b0;
        chk($sformatf("xfer %02h t=%0d {e,rs,rw,ready,db}", data, t),
            32'({lcd_e, lcd_rs, lcd_rw, req_ready, lcd_db}),
            32'({segs[s].e, rs, 1'b0, 1'b0, segs[s].db}));
      end
    end
    @(negedge clk);
    chk($sformatf("ready_return %02h", data), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    int base, nx, d;
    logic rs;
    logic [7:0] data;

    for (int i = 0; i < N_STEP; i++) begin
`ifdef LCD_4BIT_MODE_EN
      init_exp.push_back({init_bytes[i][7:4], 4'h0});
      if (!init_nib[i]) init_exp.push_back({init_bytes[i][3:0], 4'h0});
`else
      init_exp.push_back(init_bytes[i]);
`endif
    end

    repeat (2) @(negedge clk);
    chk("reset_e", 32'(lcd_e), 32'd0);
    chk("reset_rs", 32'(lcd_rs), 32'd0);
    chk("reset_rw", 32'(lcd_rw), 32'd0);
    chk("reset_db", 32'(lcd_db), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);

    run_init(1'b0);

    vecs[0] = '{1'b1, 8'h41, D_CMD};
    vecs[1] = '{1'b0, 8'h01, D_SLOW};
    vecs[2] = '{1'b0, 8'h80, D_CMD};
    vecs[3] = '{1'b0, 8'h02, D_SLOW};
    vecs[4] = '{1'b0, 8'h03, D_SLOW};
    vecs[5] = '{1'b1, 8'h01, D_CMD};
    vecs[6] = '{1'b0, 8'h04, D_CMD};
    vecs[7] = '{1'b0, 8'h00, D_CMD};
    vecs[8] = '{1'b1, 8'h5A, D_CMD};
    base = fall_q.size();
    nx = 0;
    for (int i = 0; i < 9; i++) begin
      do_write(vecs[i].rs, vecs[i].data, vecs[i].exp_d, i == 2);
      nx++;
    end

    for (int i = 0; i < 30; i++) begin
      rs   = 1'($urandom_range(0, 1));
      data = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      d    = (rs == 1'b0 && data inside {8'h01, 8'h02, 8'h03}) ? D_SLOW : D_CMD;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_write(rs, data, d, $urandom_range(0, 3) == 0);
      nx++;
    end
    chk("total_fall_count", 32'(fall_q.size() - base), 32'(nx * PULSES));

    // abort a data write while E is high
    wait_ready;
    req_rs = 1'b1; req_data = 8'h77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("e_high_before_reset", 32'(lcd_e), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_e", 32'(lcd_e), 32'd0);
    chk("abort_db", 32'(lcd_db), 32'd0);
    chk("abort_rs", 32'(lcd_rs), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);

    run_init(1'b1);
    base = fall_q.size();
    do_write(1'b1, 8'h55, D_CMD, 1'b0);
    repeat (10) @(negedge clk);
    chk("one_xfer_per_req", 32'(fall_q.size() - base), 32'(PULSES));
    chk("idle_after_held_req", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
